// File: rtl/apb_master_bridge.sv
// APB4 requester: turns a valid/ready command into one APB transfer and returns a valid/ready response.
// Optional access-phase timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [3:0]        pstrb,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [3:0]        pstrb_q, pstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Limit is hit on the edge that would make the count reach TIMEOUT_CYCLES.
  assign timeout = (state_q == ACCESS) && !pready &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP)
      cnt_d = '0;
    else if (state_q == ACCESS && !pready)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid)         state_d = SETUP;
      SETUP:                          state_d = ACCESS;
      ACCESS:  if (pready || timeout) state_d = RESP;
      RESP:    if (rsp_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (state_q == IDLE && cmd_valid) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_write ? cmd_wdata : '0;
      pstrb_d  = cmd_write ? cmd_strb  : '0;
      rdata_d  = '0;
      err_d    = 1'b0;
    end else if (state_q == ACCESS) begin
      if (pready) begin
        rdata_d = pwrite_q ? '0 : prdata;
        err_d   = pslverr;
      end else if (timeout) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  // Decoded from the state flop so async reset clears the handshakes at once.
  always_comb begin
    cmd_ready = rst_n && (state_q == IDLE);
    psel      = (state_q == SETUP) || (state_q == ACCESS);
    penable   = (state_q == ACCESS);
    rsp_valid = (state_q == RESP);
  end

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: acts as APB completer and command/response agent; expected
// cycle-by-cycle bus phases and responses are derived from the transfer parameters.
module tb_apb_master_bridge;
  localparam int unsigned AW = 12;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 256;
`endif

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, pready, pslverr;
  logic [3:0]    pstrb;
  logic [31:0]   pwdata, prdata;

  int unsigned vec = 0;
  int unsigned bad = 0;

  apb_master_bridge #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [AW-1:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] st);
    chk({tag, "_paddr"}, paddr, a);
    chk({tag, "_pwrite"}, pwrite, w);
    chk({tag, "_pwdata"}, pwdata, wd);
    chk({tag, "_pstrb"}, pstrb, st);
  endtask

  task automatic scramble_cmd();
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
  endtask

  // Starts and ends just after a negedge with the bridge idle.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input int unsigned waits, input logic [31:0] rd,
                      input logic se, input int unsigned bp);
    logic [31:0] exp_wd, exp_rd;
    logic [3:0]  exp_st;
    exp_wd = w ? wd : 32'h0;
    exp_st = w ? st : 4'h0;
    exp_rd = w ? 32'h0 : rd;
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = st;
    @(negedge clk);
    cmd_valid = 1'b0;
    scramble_cmd();
    chk("setup_psel", psel, 1'b1);
    chk("setup_penable", penable, 1'b0);
    chk("setup_cmd_ready", cmd_ready, 1'b0);
    chk("setup_rsp_valid", rsp_valid, 1'b0);
    chk_bus("setup", a, w, exp_wd, exp_st);
    for (int unsigned i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk("access_psel", psel, 1'b1);
      chk("access_penable", penable, 1'b1);
      chk("access_rsp_valid", rsp_valid, 1'b0);
      chk_bus("access", a, w, exp_wd, exp_st);
      pready  = (i == waits);
      prdata  = (i == waits) ? rd : $urandom;
      pslverr = (i == waits) ? se : 1'($urandom);
    end
    @(negedge clk);
    pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
    chk("resp_valid", rsp_valid, 1'b1);
    chk("resp_psel", psel, 1'b0);
    chk("resp_penable", penable, 1'b0);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", rsp_err, se);
    chk("resp_cmd_ready", cmd_ready, 1'b0);
    if (bp > 0) cmd_valid = 1'b1;
    for (int unsigned i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_rdata", rsp_rdata, exp_rd);
      chk("bp_err", rsp_err, se);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      chk("bp_psel", psel, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", rsp_valid, 1'b0);
    chk("done_cmd_ready", cmd_ready, 1'b1);
    chk("done_psel", psel, 1'b0);
    chk_bus("idle_hold", a, w, exp_wd, exp_st);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("withdrawn_psel", psel, 1'b0);
    chk("withdrawn_cmd_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk_bus("rst", '0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(1'b1, 12'h000, 32'h12345678, 4'hF, 0, 32'hDEADBEEF, 1'b0, 0);
    xfer(1'b0, 12'h204, 32'h55555555, 4'hA, 3, 32'h90ABCDEF, 1'b0, 0);
    xfer(1'b0, 12'h3FC, 32'h0, 4'h0, 0, 32'h13572468, 1'b1, 0);
    xfer(1'b1, 12'h010, 32'hCAFEF00D, 4'h3, 1, 32'h0, 1'b0, 5);

    for (int n = 0; n < 16; n++)
      xfer(1'($urandom), AW'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
           $urandom, 1'($urandom), $urandom_range(0, 3));

    // Reset while in ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h0AA; cmd_wdata = 32'h1; cmd_strb = 4'h1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_penable", penable, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_psel", psel, 1'b0);
    chk("midrst_penable", penable, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_cmd_ready", cmd_ready, 1'b1);
    chk("postrst_psel", psel, 1'b0);
    @(negedge clk);

    // Reset while holding an error response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h0BB;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hA5A5A5A5;
    @(negedge clk);
    pready = 1'b0; pslverr = 1'b0;
    chk("pre_rst_rsp_valid", rsp_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("resprst_rsp_valid", rsp_valid, 1'b0);
    chk("resprst_rsp_err", rsp_err, 1'b0);
    chk("resprst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("resprst_cmd_ready", cmd_ready, 1'b1);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 12'h123, 32'h0, 4'h0, TO - 1, 32'h2468ACE0, 1'b0, 0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h456;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int unsigned i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_wait_penable", penable, 1'b1);
      pready = 1'b0; prdata = 32'hFFFFFFFF; pslverr = 1'b0;
    end
    @(negedge clk);
    chk("to_psel", psel, 1'b0);
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("to_done_rsp_valid", rsp_valid, 1'b0);
`else
    xfer(1'b0, 12'h456, 32'h0, 4'h0, 1000, 32'h0F0F0F0F, 1'b0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
